// File: rtl/cpu_controller_if.sv
// Control/status bundle between the CPU controller and its datapath.
interface cpu_controller_if #(
  parameter int unsigned OPCODE = 3,
  parameter int unsigned CNT_W  = 8
);
  logic              run;
  logic [OPCODE-1:0] opcode;
  logic              zero;
  logic              sel;
  logic              rd;
  logic              ld_ir;
  logic              inc_pc;
  logic              ld_pc;
  logic              ld_ac;
  logic              wr;
  logic              data_e;
  logic              halt;
  logic [2:0]        phase;
  logic [CNT_W-1:0]  retired;

  // Datapath / stimulus side
  modport master (
    output run, opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, retired
  );

  // Controller side
  modport slave (
    input  run, opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, retired
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for a simple accumulator CPU.
// Control strobes are decoded from the current phase and the live
// opcode/zero inputs; only the phase and the retired count are stored.
module cpu_controller #(
  parameter int unsigned OPCODE = 3,
  parameter int unsigned CNT_W  = 8
) (
  input logic           clk,
  input logic           reset,
  cpu_controller_if.slave bus
);

  localparam logic [OPCODE-1:0] OP_HLT = OPCODE'(0);
  localparam logic [OPCODE-1:0] OP_SKZ = OPCODE'(1);
  localparam logic [OPCODE-1:0] OP_ADD = OPCODE'(2);
  localparam logic [OPCODE-1:0] OP_AND = OPCODE'(3);
  localparam logic [OPCODE-1:0] OP_XOR = OPCODE'(4);
  localparam logic [OPCODE-1:0] OP_LDA = OPCODE'(5);
  localparam logic [OPCODE-1:0] OP_STO = OPCODE'(6);
  localparam logic [OPCODE-1:0] OP_JMP = OPCODE'(7);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] retired_q;

  logic is_alu;
  logic is_skz;
  logic is_jmp;
  logic is_sto;
  logic is_hlt;

  assign is_alu = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
  assign is_skz = (bus.opcode == OP_SKZ);
  assign is_jmp = (bus.opcode == OP_JMP);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_hlt = (bus.opcode == OP_HLT);

  // Phase sequencer and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= INST_ADDR;
      retired_q <= '0;
    end else begin
      case (state)
        INST_ADDR:  if (bus.run) state <= INST_FETCH;
        INST_FETCH: state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR:    state <= is_hlt ? HALTED : OP_FETCH;
        OP_FETCH:   state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE: begin
          state     <= INST_ADDR;
          retired_q <= retired_q + CNT_W'(1);
        end
        HALTED:     state <= HALTED;
        default:    state <= INST_ADDR;
      endcase
    end
  end

  // Control strobe decode; while reset is held the INST_ADDR pattern is shown
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    bus.phase  = 3'd0;
    if (!reset) begin
      bus.sel = 1'b1;
    end else begin
      bus.phase = (state == HALTED) ? 3'd7 : state[2:0];
      case (state)
        INST_ADDR: bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = is_hlt;
        end
        OP_FETCH: bus.rd = is_alu;
        ALU_OP: begin
          bus.rd     = is_alu;
          bus.inc_pc = is_skz && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = is_alu;
          bus.ld_ac  = is_alu;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        HALTED: bus.halt = 1'b1;
        default: bus.sel = 1'b1;
      endcase
    end
  end

  assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: a cycle model pushes expected
// outputs into a scoreboard queue that is drained at each sample point.
module tb_cpu_controller;

  localparam int unsigned OPCODE = 3;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [8:0]       ctl;
    logic [2:0]       ph;
    logic [CNT_W-1:0] ret;
  } exp_t;

  logic clk;
  logic reset;

  cpu_controller_if #(.OPCODE(OPCODE), .CNT_W(CNT_W)) bus ();

  cpu_controller #(.OPCODE(OPCODE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  // model state
  int   m_ph;
  bit   m_hlt;
  int   m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_ctl(input int ph, input bit hlt,
                                         input logic [2:0] op, input logic z,
                                         input logic rst);
    logic sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic alu;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt} = 9'b0;
    if (!rst) sel = 1'b1;
    else if (hlt) halt = 1'b1;
    else begin
      case (ph)
        0: sel = 1'b1;
        1: begin sel = 1'b1; rd = 1'b1; end
        2, 3: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        4: begin inc_pc = 1'b1; halt = (op == 3'd0); end
        5: rd = alu;
        6: begin
          rd = alu; inc_pc = (op == 3'd1) && z;
          ld_pc = (op == 3'd7); data_e = (op == 3'd6);
        end
        default: begin
          rd = alu; ld_ac = alu; ld_pc = (op == 3'd7);
          wr = (op == 3'd6); data_e = (op == 3'd6);
        end
      endcase
    end
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  // One clock: drive inputs, predict, sample at negedge, advance model
  task automatic cycle(input logic rst, input logic rn, input logic [2:0] op, input logic z);
    exp_t e;
    exp_t p;
    logic [8:0] got_ctl;
    reset      = rst;
    bus.run    = rn;
    bus.opcode = op;
    bus.zero   = z;
    e.ctl = exp_ctl(m_ph, m_hlt, op, z, rst);
    e.ph  = !rst ? 3'd0 : (m_hlt ? 3'd7 : 3'(m_ph));
    e.ret = CNT_W'(m_ret);
    sb_q.push_back(e);
    @(negedge clk);
    p = sb_q.pop_front();
    got_ctl = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
               bus.wr, bus.data_e, bus.halt};
    check("ctl", 32'(got_ctl), 32'(p.ctl));
    check("phase", 32'(bus.phase), 32'(p.ph));
    check("retired", 32'(bus.retired), 32'(p.ret));
    check("rd_wr_excl", 32'(bus.rd & bus.wr), 32'd0);
    check("pc_excl", 32'(bus.ld_pc & bus.inc_pc), 32'd0);
    if (!rst) begin
      m_ph = 0; m_hlt = 1'b0; m_ret = 0;
    end else if (m_hlt) begin
      m_hlt = 1'b1;
    end else if (m_ph == 0) begin
      m_ph = rn ? 1 : 0;
    end else if (m_ph == 4 && op == 3'd0) begin
      m_hlt = 1'b1;
    end else if (m_ph == 7) begin
      m_ph = 0; m_ret = (m_ret + 1) % (1 << CNT_W);
    end else begin
      m_ph++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [2:0] op, input logic z);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, op, z);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    m_ph = 0; m_hlt = 1'b0; m_ret = 0;
    reset = 1'b0; bus.run = 1'b0; bus.opcode = 3'd0; bus.zero = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    cycle(1'b0, 1'b1, 3'd2, 1'b0);
    cycle(1'b0, 1'b0, 3'd7, 1'b1);

    // ADD, then explicit retire count
    instr(3'd2, 1'b0);
    check("add_retired", 32'(bus.retired), 32'd1);

    // STO, SKZ taken/not-taken, JMP, AND/XOR/LDA
    instr(3'd6, 1'b0);
    instr(3'd1, 1'b1);
    instr(3'd1, 1'b0);
    instr(3'd7, 1'b0);
    instr(3'd3, 1'b1);
    instr(3'd4, 1'b0);
    instr(3'd5, 1'b0);
    check("mix_retired", 32'(bus.retired), 32'd8);

    // run dropped mid-instruction: instruction still completes
    cycle(1'b1, 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 3'd3, 1'b0);
    cycle(1'b1, 1'b0, 3'd3, 1'b0);
    cycle(1'b1, 1'b0, 3'd3, 1'b0);
    check("run_drop_retired", 32'(bus.retired), 32'd9);

    // opcode/zero wander mid-instruction (HLT may occur)
    for (int i = 0; i < 48; i++)
      cycle(1'b1, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    // HLT: one ADD first so retired is non-zero, then halt for 20 clocks
    cycle(1'b0, 1'b0, 3'd0, 1'b0);
    instr(3'd2, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    check("hlt_retired", 32'(bus.retired), 32'd1);
    check("hlt_halt", 32'(bus.halt), 32'd1);
    cycle(1'b0, 1'b1, 3'd0, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 1'b0);
    check("hlt_reset_retired", 32'(bus.retired), 32'd0);

    // reset in ALU_OP of a JMP
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 3'd7, 1'b0);
    cycle(1'b0, 1'b1, 3'd7, 1'b0);
    cycle(1'b1, 1'b0, 3'd7, 1'b0);
    check("jmp_abort_retired", 32'(bus.retired), 32'd0);

    // run held low 5 clocks, then 256 ADDs wrap the counter
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 3'd2, 1'b0);
    for (int k = 0; k < 256; k++) instr(3'd2, 1'b0);
    check("wrap_retired", 32'(bus.retired), 32'd0);
    check("wrap_phase", 32'(bus.phase), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have parameter OPCODE, default 3, the opcode width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the retired-instruction counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 The block SHALL have port run  input  1  start permit, sampled only in INST_ADDR.
REQ-006 The block SHALL have port opcode  input  OPCODE  current instruction-register opcode field.
REQ-007 The block SHALL have port zero  input  1  accumulator-is-zero flag.
REQ-008 The block SHALL have the following 1-bit outputs: sel (PC drives the address bus), rd (memory read), ld_ir (load instruction register), inc_pc (increment PC), ld_pc (load PC from operand), ld_ac (load accumulator), wr (memory write), data_e (accumulator drives the data bus), halt (halted).
REQ-009 The block SHALL have port phase  output  3  current phase encoding.
REQ-010 The block SHALL have port retired  output  CNT_W  count of completed instructions.

Function
REQ-011 Opcode map SHALL be: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP means ADD, AND, XOR or LDA.
REQ-012 The FSM SHALL have these states and phase encodings: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, plus HALTED, which reports phase=7.
REQ-013 Transitions SHALL be:
- INST_ADDR to INST_FETCH when run=1; otherwise stay in INST_ADDR.
- Phases 1 through 6 advance one per clock, unconditionally.
- STORE to INST_ADDR.
- OP_ADDR to HALTED when opcode=HLT.
- HALTED stays until reset.
REQ-014 Outputs SHALL be combinational decodes of the current state and the current opcode/zero inputs; any signal not listed for a state is 0:
- INST_ADDR: sel.
- INST_FETCH: sel, rd.
- INST_LOAD: sel, rd, ld_ir.
- IDLE: sel, rd, ld_ir.
- OP_ADDR: inc_pc; halt if opcode=HLT.
- OP_FETCH: rd if ALUOP.
- ALU_OP: rd if ALUOP; inc_pc if SKZ and zero=1; ld_pc if JMP; data_e if STO.
- STORE: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
- HALTED: halt only.
REQ-015 One instruction SHALL take exactly 8 clocks from INST_ADDR back to INST_ADDR when run is held at 1.
REQ-016 retired SHALL increment by 1 on each STORE-to-INST_ADDR transition and wrap from 2^CNT_W-1 to 0.
REQ-017 HLT SHALL NOT increment retired.
REQ-018 wr and rd SHALL never be 1 in the same cycle.
REQ-019 ld_pc and inc_pc SHALL never be 1 in the same cycle.
REQ-020 run=0 seen in any state other than INST_ADDR SHALL have no effect; the current instruction completes.
REQ-021 opcode and zero changes mid-instruction SHALL affect only the outputs of the cycle in which they are sampled; they SHALL NOT be latched.

Reset
REQ-022 reset=0 at a rising clk SHALL force state INST_ADDR and retired=0, overriding run and any in-progress phase, including HALTED.
REQ-023 During and immediately after reset, the outputs SHALL be sel=1, all other 1-bit outputs 0, phase=0.
REQ-024 reset asserted mid-instruction SHALL abandon that instruction, with no wr or ld_ac pulse in the following cycle and no retired increment.

Verification
REQ-025 Reset then run=1 with opcode=2 (ADD) held: phase SHALL sequence 0,1,...,7,0; rd=1 in phases 1,2,3,5,6,7; ld_ac=1 only in phase 7; retired=1 after the 8th clock.
REQ-026 opcode=6 (STO): wr=1 only in phase 7; data_e=1 in phases 6 and 7; rd=0 in phases 5 through 7.
REQ-027 opcode=1 (SKZ): with zero=1, inc_pc=1 in phases 4 and 6; with zero=0, inc_pc=1 in phase 4 only.
REQ-028 opcode=0 (HLT): halt=1 in phase 4, then HALTED persists 20 clocks with only halt=1 and retired unchanged; reset=0 for one clock returns phase=0 with retired=0.
REQ-029 run=0 after reset: the FSM SHALL hold phase 0 for 5 clocks; after run=1 it SHALL reach phase 1 on the next clock; 256 ADD instructions SHALL wrap retired to 0.
REQ-030 reset=0 asserted in phase 6 with opcode=7 (JMP): the next cycle SHALL be phase 0 with ld_pc=0 and retired unchanged at 0.
